// File: rtl/ft2232h_rx_reader.sv
// FT2232H sync-FIFO receive controller with a local FWFT byte buffer.
// Optional byte counter on rx_count_o: define FT_RX_BYTE_COUNT_EN.
module ft2232h_rx_reader #(
  parameter int FIFO_AW     = 4,
  parameter int SKID_MARGIN = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [7:0]         data_i,
  input  logic               rxf_n_i,
  output logic               oe_n_o,
  output logic               rd_n_o,
  output logic [7:0]         dout_o,
  output logic               dout_valid_o,
  input  logic               dout_ready_i,
  output logic [FIFO_AW:0]   fill_o,
  output logic               overflow_o,
  output logic [31:0]        rx_count_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    IDLE,
    OE,
    READ
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_ptr_n;
  logic [FIFO_AW:0]   fill_n;
  logic [7:0]         head_n;
  logic               xfer;
  logic               pop;
  logic               push;
  logic               full;
  logic               drop;
  int                 free_now;
  int                 free_next;

  always_comb begin
    xfer      = (state == READ) && !rd_n_o && !rxf_n_i;
    pop       = dout_valid_o && dout_ready_i;
    full      = fill_o == (FIFO_AW+1)'(DEPTH);
    push      = xfer && (!full || pop);
    drop      = xfer && full && !pop;
    fill_n    = fill_o + (FIFO_AW+1)'(push)
              - (FIFO_AW+1)'(pop);
    rd_ptr_n  = rd_ptr + FIFO_AW'(pop);
    free_now  = DEPTH - int'(fill_o);
    free_next = DEPTH - int'(fill_n);
    head_n    = dout_o;
    // New head is the incoming byte only when the pop leaves nothing behind it
    if (fill_n != '0) begin
      if (push && fill_o == (FIFO_AW+1)'(pop))
        head_n = data_i;
      else
        head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      oe_n_o <= 1'b1;
      rd_n_o <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxf_n_i && free_now > SKID_MARGIN) begin
            state  <= OE;
            oe_n_o <= 1'b0;
          end
        end
        OE: begin
          if (rxf_n_i) begin
            state  <= IDLE;
            oe_n_o <= 1'b1;
          end else begin
            state  <= READ;
            rd_n_o <= 1'b0;
          end
        end
        READ: begin
          if (rxf_n_i || free_next <= SKID_MARGIN) begin
            state  <= IDLE;
            oe_n_o <= 1'b1;
            rd_n_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          oe_n_o <= 1'b1;
          rd_n_o <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_o       <= '0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr       <= rd_ptr_n;
      fill_o       <= fill_n;
      dout_o       <= head_n;
      dout_valid_o <= fill_n != '0;
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef FT_RX_BYTE_COUNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      rx_count_o <= '0;
    else if (push)
      rx_count_o <= rx_count_o + 32'd1;
  end
`else
  assign rx_count_o = 32'h0;
`endif

endmodule
